multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RV32I control path: one FSM sequences fetch/decode/execute/memory/writeback over several clocks.
- Memory accesses use a shared instruction/data port with a ready handshake.
- Drives datapath muxes, write strobes and ALU control.
- Adds a retired-instruction counter and a sticky illegal-instruction halt.

Parameters:
- ALU_CTRL_W, 3: aluControl width. Legal values are 3 or 4; 4 enables the xor/srl/sll encodings.
- CNT_W, 32: width of the instret counter.
- BRANCH_EXT, 1: 1 decodes bne/blt/bge in addition to beq; 0 treats those as illegal.

Ports:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high.
- op, in, 7: instr[6:0] from the instruction register.
- funct3, in, 3: instr[14:12].
- funct7, in, 7: instr[31:25].
- zero, in, 1: ALU result == 0.
- aluLt, in, 1: ALU signed less-than flag, valid while ALU is subtracting.
- memReady, in, 1: memory access completes this cycle.
- pcWrite, out, 1: PC register enable.
- adrSrc, out, 1: memory address select (0 = PC, 1 = ALUOut).
- memWrite, out, 1: memory write strobe.
- irWrite, out, 1: instruction register (and oldPC) enable.
- resultSrc, out, 2: 00 = ALUOut, 01 = data, 10 = ALU result.
- aluSrcA, out, 2: 00 = PC, 01 = oldPC, 10 = rs1.
- aluSrcB, out, 2: 00 = rs2, 01 = imm, 10 = 4.
- immSrc, out, 2: 00 = I, 01 = S, 10 = B, 11 = J.
- regWrite, out, 1: register file write enable.
- aluControl, out, ALU_CTRL_W: ALU operation.
- illegal, out, 1: sticky; set in HALT.
- instret, out, CNT_W: count of retired instructions.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, HALT. State is registered; outputs are combinational from state, op and funct.
- Reset: state <= FETCH, instret <= 0, illegal <= 0. While reset is high, pcWrite, irWrite, memWrite and regWrite are forced to 0. Reset mid-access aborts immediately with no write.
- FETCH:
  - adrSrc=0, aluSrcA=00, aluSrcB=10, aluControl=add, resultSrc=10.
  - irWrite = pcWrite = memReady.
  - Stay in FETCH while !memReady; go to DECODE on memReady.
- DECODE:
  - aluSrcA=01, aluSrcB=01, immSrc=10, aluControl=add (precomputes the branch target).
  - Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BRANCH; 1101111 -> JAL.
  - Any other op, or a branch funct3 that is not enabled, -> HALT.
- MEMADR:
  - aluSrcA=10, aluSrcB=01, add.
  - immSrc = 01 for stores, 00 for loads.
  - Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: resultSrc=00, adrSrc=1. Wait for memReady, then MEMWB.
- MEMWB: resultSrc=01, regWrite=1. Retires; -> FETCH.
- MEMWRITE: resultSrc=00, adrSrc=1, memWrite=1 held until memReady. Retires on memReady; -> FETCH.
- EXECUTER / EXECUTEI:
  - aluSrcA=10; aluSrcB = 00 (R) or 01 (I, immSrc=00).
  - aluControl decoded from funct3/funct7.
  - Next: ALUWB.
- ALUWB: resultSrc=00, regWrite=1. Retires; -> FETCH.
- BRANCH:
  - aluSrcA=10, aluSrcB=00, sub, resultSrc=00.
  - pcWrite = taken, where taken is: beq zero; bne !zero; blt aluLt; bge !aluLt.
  - Retires; -> FETCH.
- JAL:
  - Cycle 1: aluSrcA=01, aluSrcB=10, add, resultSrc=00, pcWrite=1. The earlier DECODE target must be with immSrc=11; DECODE uses immSrc=11 when op=1101111.
  - Cycle 2: ALUWB, writes PC+4 to rd. Retires there.
- ALU encoding:
  - add 000, sub 001, and 010, or 011, slt 101.
  - When ALU_CTRL_W=4: values are zero-extended, plus xor 0100, srl 0110, sll 0111.
  - R-type sub when funct3=000 and funct7[5]=1; I-type never subtracts.
  - Unsupported funct3 in R/I -> HALT, checked in DECODE.
- HALT: all strobes 0; illegal=1. Exit only via reset.
- instret: increments by 1 on every retire cycle (memReady-qualified for sw), wraps modulo 2^CNT_W. There is no retire in the cycle reset is high.
- Latency with memReady=1 always:
  - R/I: 4 cycles. lw: 5. sw: 4. branch: 3. jal: 4.
  - Each !memReady cycle adds 1.

Decomposition:
- Shared package holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL);
  - the state enum;
  - ALU op encodings;
  - immSrc/resultSrc/aluSrc mux encodings.
- One combinational sub-module, mc_alu_decoder (funct3/funct7/op-class -> aluControl, legal flag), parametrised by ALU_CTRL_W.

Test Plan:
- add x3,x1,x2 (0x002081B3), memReady=1:
  - states FETCH, DECODE, EXECUTER, ALUWB;
  - aluControl=000 in EXECUTER;
  - regWrite=1 only in cycle 4;
  - instret 0 -> 1.
- lw (0x0000A183) with memReady low for 2 cycles in FETCH and 3 in MEMREAD:
  - irWrite and pcWrite pulse once;
  - regWrite in MEMWB at cycle 10;
  - no strobes while waiting.
- bne (0x00209463):
  - zero=1 -> pcWrite=0 in BRANCH;
  - zero=0 -> pcWrite=1;
  - with BRANCH_EXT=0 -> HALT, illegal=1.
- op=0x7F: DECODE -> HALT; illegal stays 1 for 20 cycles; reset returns to FETCH with illegal=0.
- Reset asserted in MEMWRITE with memReady=1 that cycle: memWrite=0, no instret increment, state FETCH next.
- CNT_W=4: retire 17 instructions -> instret=1 (wrap). ALU_CTRL_W=4, xor -> aluControl=0100.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit_pkg
// Description : Shared opcodes, FSM states, ALU and datapath mux encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_unit_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // beq is always available; the other compares only with the extension.
    function automatic logic branch_f3_legal(input logic [2:0] f3, input logic ext);
        case (f3)
            F3_BEQ:                 return 1'b1;
            F3_BNE, F3_BLT, F3_BGE: return ext;
            default:                return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mc_alu_decoder
// Description : funct3/funct7 + op class -> ALU control and legality flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_alu_decoder
    import multicycle_control_unit_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic [2:0]            i_funct3,
    input  logic                  i_funct7_b5,
    input  logic                  i_is_rtype,
    output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
    output logic                  o_legal
);

    localparam logic c_HAS_EXT = (ALU_CTRL_W == 4);

    logic [3:0] w_code;

    always_comb begin
        w_code  = ALU_ADD;
        o_legal = 1'b1;
        case (i_funct3)
            3'b000: w_code = (i_is_rtype && i_funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b010: w_code = ALU_SLT;
            3'b110: w_code = ALU_OR;
            3'b111: w_code = ALU_AND;
            3'b100: begin
                w_code  = ALU_XOR;
                o_legal = c_HAS_EXT;
            end
            // funct7[5] here selects the arithmetic shift, which is not offered
            3'b101: begin
                w_code  = ALU_SRL;
                o_legal = c_HAS_EXT && !i_funct7_b5;
            end
            3'b001: begin
                w_code  = ALU_SLL;
                o_legal = c_HAS_EXT;
            end
            default: o_legal = 1'b0;
        endcase
    end

    if (ALU_CTRL_W == 4) begin : g_ctrl_w4
        assign o_alu_ctrl = w_code;
    end else begin : g_ctrl_w3
        logic w_unused_msb;
        assign w_unused_msb = w_code[3];
        assign o_alu_ctrl   = w_code[ALU_CTRL_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Multi-cycle RV32I control FSM with retire counter and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter int CNT_W      = 32,
    parameter int BRANCH_EXT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  zero,
    input  logic                  aluLt,
    input  logic                  memReady,
    output logic                  pcWrite,
    output logic                  adrSrc,
    output logic                  memWrite,
    output logic                  irWrite,
    output logic [1:0]            resultSrc,
    output logic [1:0]            aluSrcA,
    output logic [1:0]            aluSrcB,
    output logic [1:0]            immSrc,
    output logic                  regWrite,
    output logic [ALU_CTRL_W-1:0] aluControl,
    output logic                  illegal,
    output logic [CNT_W-1:0]      instret
);

    localparam logic [ALU_CTRL_W-1:0] c_ALU_ADD = ALU_ADD[ALU_CTRL_W-1:0];
    localparam logic [ALU_CTRL_W-1:0] c_ALU_SUB = ALU_SUB[ALU_CTRL_W-1:0];

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_instret;
    logic                    r_illegal;
    logic                    w_retire;
    logic                    w_taken;
    logic                    w_is_rtype;
    logic                    w_br_legal;
    logic                    w_dec_legal;
    logic [ALU_CTRL_W-1:0]   w_dec_ctrl;
    logic                    w_unused_funct7;

    assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};
    assign w_is_rtype      = (op == OP_R);
    assign w_br_legal      = branch_f3_legal(funct3, BRANCH_EXT != 0);

    mc_alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_dec (
        .i_funct3    (funct3),
        .i_funct7_b5 (funct7[5]),
        .i_is_rtype  (w_is_rtype),
        .o_alu_ctrl  (w_dec_ctrl),
        .o_legal     (w_dec_legal)
    );

    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            F3_BEQ:  w_taken = zero;
            F3_BNE:  w_taken = !zero;
            F3_BLT:  w_taken = aluLt;
            F3_BGE:  w_taken = !aluLt;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // All legality is resolved in DECODE so later states never see a bad op.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH:    w_state_next = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  w_state_next = S_MEMADR;
                    OP_R:      w_state_next = w_dec_legal ? S_EXECUTER : S_HALT;
                    OP_I:      w_state_next = w_dec_legal ? S_EXECUTEI : S_HALT;
                    OP_BRANCH: w_state_next = w_br_legal  ? S_BRANCH   : S_HALT;
                    OP_JAL:    w_state_next = S_JAL;
                    default:   w_state_next = S_HALT;
                endcase
            end
            S_MEMADR:   w_state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_state_next = memReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_state_next = S_FETCH;
            S_MEMWRITE: w_state_next = memReady ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_state_next = S_ALUWB;
            S_EXECUTEI: w_state_next = S_ALUWB;
            S_ALUWB:    w_state_next = S_FETCH;
            S_BRANCH:   w_state_next = S_FETCH;
            S_JAL:      w_state_next = S_ALUWB;
            S_HALT:     w_state_next = S_HALT;
            default:    w_state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pcWrite    = 1'b0;
        adrSrc     = ADR_PC;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        resultSrc  = RES_ALUOUT;
        aluSrcA    = SRCA_PC;
        aluSrcB    = SRCB_RS2;
        immSrc     = IMM_I;
        regWrite   = 1'b0;
        aluControl = c_ALU_ADD;
        w_retire   = 1'b0;
        case (r_state)
            S_FETCH: begin
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALU;
                irWrite   = memReady;
                pcWrite   = memReady;
            end
            // Branch/jump target is precomputed here into ALUOut
            S_DECODE: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
                immSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
                immSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                adrSrc = ADR_ALUOUT;
            end
            S_MEMWB: begin
                resultSrc = RES_DATA;
                regWrite  = 1'b1;
                w_retire  = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc   = ADR_ALUOUT;
                memWrite = 1'b1;
                w_retire = memReady;
            end
            S_EXECUTER: begin
                aluSrcA    = SRCA_RS1;
                aluControl = w_dec_ctrl;
            end
            S_EXECUTEI: begin
                aluSrcA    = SRCA_RS1;
                aluSrcB    = SRCB_IMM;
                aluControl = w_dec_ctrl;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                w_retire = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA    = SRCA_RS1;
                aluControl = c_ALU_SUB;
                pcWrite    = w_taken;
                w_retire   = 1'b1;
            end
            // ALUOut still holds the target; the ALU forms oldPC+4 for rd
            S_JAL: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_FOUR;
                pcWrite = 1'b1;
            end
            default: begin
            end
        endcase
        if (reset) begin
            pcWrite  = 1'b0;
            irWrite  = 1'b0;
            memWrite = 1'b0;
            regWrite = 1'b0;
            w_retire = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instret <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (w_state_next == S_HALT) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign illegal = r_illegal;
    assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Randomized instruction-level scoreboard bench for the control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_control_unit;

    localparam logic [6:0] OPC_LOAD  = 7'h03;
    localparam logic [6:0] OPC_STORE = 7'h23;
    localparam logic [6:0] OPC_R     = 7'h33;
    localparam logic [6:0] OPC_I     = 7'h13;
    localparam logic [6:0] OPC_BR    = 7'h63;
    localparam logic [6:0] OPC_JAL   = 7'h6F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: wide ALU control, 4-bit counter, all branches.
    logic       reset, zero, aluLt, memReady;
    logic [6:0] op, funct7;
    logic [2:0] funct3;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [3:0] aluControl, instret;

    multicycle_control_unit #(.ALU_CTRL_W(4), .CNT_W(4), .BRANCH_EXT(1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .aluLt(aluLt), .memReady(memReady),
        .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
        .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .immSrc(immSrc),
        .regWrite(regWrite), .aluControl(aluControl), .illegal(illegal), .instret(instret)
    );

    // Second DUT with default widths and no branch extension.
    logic        b_reset;
    logic [6:0]  b_op, b_f7;
    logic [2:0]  b_f3;
    logic        b_pcw, b_adr, b_mw, b_irw, b_rw, b_ill;
    logic [1:0]  b_rs, b_sa, b_sb, b_imm;
    logic [2:0]  b_alu;
    logic [31:0] b_cnt;

    multicycle_control_unit #(.ALU_CTRL_W(3), .CNT_W(32), .BRANCH_EXT(0)) dut_b (
        .clk(clk), .reset(b_reset), .op(b_op), .funct3(b_f3), .funct7(b_f7),
        .zero(1'b0), .aluLt(1'b0), .memReady(1'b1),
        .pcWrite(b_pcw), .adrSrc(b_adr), .memWrite(b_mw), .irWrite(b_irw),
        .resultSrc(b_rs), .aluSrcA(b_sa), .aluSrcB(b_sb), .immSrc(b_imm),
        .regWrite(b_rw), .aluControl(b_alu), .illegal(b_ill), .instret(b_cnt)
    );

    typedef struct {
        logic [79:0] st;
        logic        pcw, adr, mw, irw, rw, ill;
        logic [1:0]  rs, sa, sb, imm;
        logic [3:0]  alu, cnt;
        logic [5:0]  care;   // adr, rs, sa, sb, imm, alu
    } exp_t;

    exp_t q[$];
    int   m_cnt = 0;
    bit   m_ill = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic exp_t mk(input logic [79:0] st, input int adr, input int rs,
                                input int sa, input int sb, input int imm, input int alu);
        exp_t e;
        e.st  = st;
        e.pcw = 1'b0; e.mw = 1'b0; e.irw = 1'b0; e.rw = 1'b0;
        e.ill = m_ill;
        e.cnt = 4'(m_cnt);
        e.adr = 1'(adr); e.rs = 2'(rs); e.sa = 2'(sa); e.sb = 2'(sb);
        e.imm = 2'(imm); e.alu = 4'(alu);
        e.care = {alu >= 0, imm >= 0, sb >= 0, sa >= 0, rs >= 0, adr >= 0};
        return e;
    endfunction

    // ALU op for an R/I instruction, or -1 when it cannot be executed.
    function automatic int alu_code(input bit is_r, input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'd0:    return (is_r && f7[5]) ? 1 : 0;
            3'd1:    return 7;
            3'd2:    return 5;
            3'd4:    return 4;
            3'd5:    return f7[5] ? -1 : 6;
            3'd6:    return 3;
            3'd7:    return 2;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input logic [79:0] st, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %0s %s: got %0h expected %0h at %0t", st, nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input exp_t e, input logic rst, input logic mr, input logic z,
                       input logic lt, input logic [31:0] ins);
        @(posedge clk);
        #1;
        reset = rst; memReady = mr; zero = z; aluLt = lt;
        op = ins[6:0]; funct3 = ins[14:12]; funct7 = ins[31:25];
        q.push_back(e);
    endtask

    task automatic retire();
        m_cnt = (m_cnt + 1) % 16;
    endtask

    task automatic aluwb(input logic [31:0] ins);
        exp_t e;
        e = mk("ALUWB", -1, 0, -1, -1, -1, -1);
        e.rw = 1'b1;
        cyc(e, 0, rb(), rb(), rb(), ins);
        retire();
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input bit rst_mem, input int halt_n, input logic z, input logic lt);
        exp_t e;
        logic [6:0] o;
        logic [2:0] f3;
        int code;
        bit taken;
        o  = ins[6:0];
        f3 = ins[14:12];
        for (int i = 0; i < fw; i++) begin
            e = mk("FETCH", 0, 2, 0, 2, -1, 0);
            cyc(e, 0, 0, rb(), rb(), $urandom);
        end
        e = mk("FETCH", 0, 2, 0, 2, -1, 0);
        e.pcw = 1'b1; e.irw = 1'b1;
        cyc(e, 0, 1, rb(), rb(), $urandom);
        e = mk("DECODE", -1, -1, 1, 1, (o == OPC_JAL) ? 3 : 2, 0);
        cyc(e, 0, rb(), rb(), rb(), ins);
        code = (o == OPC_R || o == OPC_I) ? alu_code(o == OPC_R, f3, ins[31:25]) : -1;
        if (o == OPC_LOAD || o == OPC_STORE) begin
            e = mk("MEMADR", -1, -1, 2, 1, (o == OPC_STORE) ? 1 : 0, 0);
            cyc(e, 0, rb(), rb(), rb(), ins);
            if (o == OPC_LOAD) begin
                for (int i = 0; i <= mw; i++) begin
                    e = mk("MEMREAD", 1, 0, -1, -1, -1, -1);
                    cyc(e, 0, (i == mw), rb(), rb(), ins);
                end
                e = mk("MEMWB", -1, 1, -1, -1, -1, -1);
                e.rw = 1'b1;
                cyc(e, 0, rb(), rb(), rb(), ins);
                retire();
            end else begin
                for (int i = 0; i < mw; i++) begin
                    e = mk("MEMWRITE", 1, 0, -1, -1, -1, -1);
                    e.mw = 1'b1;
                    cyc(e, 0, 0, rb(), rb(), ins);
                end
                if (rst_mem) begin
                    e = mk("MEMWR_RST", -1, -1, -1, -1, -1, -1);
                    cyc(e, 1, 1, rb(), rb(), ins);
                    m_cnt = 0; m_ill = 1'b0;
                end else begin
                    e = mk("MEMWRITE", 1, 0, -1, -1, -1, -1);
                    e.mw = 1'b1;
                    cyc(e, 0, 1, rb(), rb(), ins);
                    retire();
                end
            end
        end else if (code >= 0) begin
            if (o == OPC_R) e = mk("EXECUTER", -1, -1, 2, 0, -1, code);
            else            e = mk("EXECUTEI", -1, -1, 2, 1, 0, code);
            cyc(e, 0, rb(), rb(), rb(), ins);
            aluwb(ins);
        end else if (o == OPC_BR && (f3 == 0 || f3 == 1 || f3 == 4 || f3 == 5)) begin
            case (f3)
                3'd0:    taken = z;
                3'd1:    taken = !z;
                3'd4:    taken = lt;
                default: taken = !lt;
            endcase
            e = mk("BRANCH", -1, 0, 2, 0, -1, 1);
            e.pcw = taken;
            cyc(e, 0, rb(), z, lt, ins);
            retire();
        end else if (o == OPC_JAL) begin
            e = mk("JAL", -1, 0, 1, 2, -1, 0);
            e.pcw = 1'b1;
            cyc(e, 0, rb(), rb(), rb(), ins);
            aluwb(ins);
        end else begin
            m_ill = 1'b1;
            for (int i = 0; i < halt_n; i++) begin
                e = mk("HALT", -1, -1, -1, -1, -1, -1);
                cyc(e, 0, rb(), rb(), rb(), $urandom);
            end
            e = mk("HALT_RST", -1, -1, -1, -1, -1, -1);
            cyc(e, 1, rb(), rb(), rb(), $urandom);
            m_cnt = 0; m_ill = 1'b0;
        end
    endtask

    task automatic b_cyc(input logic r, input logic [31:0] ins);
        @(posedge clk);
        #1;
        b_reset = r; b_op = ins[6:0]; b_f3 = ins[14:12]; b_f7 = ins[31:25];
        @(negedge clk);
    endtask

    // Monitor: one expected record per cycle while the scoreboard holds any.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.st, "pcWrite",  pcWrite,  e.pcw);
                chk(e.st, "irWrite",  irWrite,  e.irw);
                chk(e.st, "memWrite", memWrite, e.mw);
                chk(e.st, "regWrite", regWrite, e.rw);
                chk(e.st, "illegal",  illegal,  e.ill);
                chk(e.st, "instret",  instret,  e.cnt);
                if (e.care[0]) chk(e.st, "adrSrc",     adrSrc,     e.adr);
                if (e.care[1]) chk(e.st, "resultSrc",  resultSrc,  e.rs);
                if (e.care[2]) chk(e.st, "aluSrcA",    aluSrcA,    e.sa);
                if (e.care[3]) chk(e.st, "aluSrcB",    aluSrcB,    e.sb);
                if (e.care[4]) chk(e.st, "immSrc",     immSrc,     e.imm);
                if (e.care[5]) chk(e.st, "aluControl", aluControl, e.alu);
            end
        end
    end

    initial begin
        exp_t        e;
        logic [31:0] ins;
        int          k;
        reset = 1'b1; memReady = 1'b0; zero = 1'b0; aluLt = 1'b0;
        op = '0; funct3 = '0; funct7 = '0;
        b_reset = 1'b1; b_op = '0; b_f3 = '0; b_f7 = '0;

        // Default-parameter instance: narrow ALU code, branch extension off.
        b_cyc(1, 32'h002081B3);
        chk("B_RESET", "instret", b_cnt, 0);
        chk("B_RESET", "illegal", b_ill, 0);
        chk("B_RESET", "irWrite", b_irw, 0);
        b_cyc(0, 32'h002081B3);
        chk("B_FETCH", "irWrite", b_irw, 1);
        b_cyc(0, 32'h002081B3);
        b_cyc(0, 32'h002081B3);
        chk("B_EXECR", "aluControl", b_alu, 3'b000);
        b_cyc(0, 32'h002081B3);
        chk("B_ALUWB", "regWrite", b_rw, 1);
        b_cyc(0, 32'h402081B3);
        chk("B_FETCH", "instret", b_cnt, 1);
        b_cyc(0, 32'h402081B3);
        b_cyc(0, 32'h402081B3);
        chk("B_EXECR", "aluControl", b_alu, 3'b001);
        b_cyc(0, 32'h402081B3);
        b_cyc(0, 32'h0020C1B3);
        b_cyc(0, 32'h0020C1B3);
        b_cyc(0, 32'h0020C1B3);
        chk("B_HALT_XOR", "illegal", b_ill, 1);
        chk("B_HALT_XOR", "regWrite", b_rw, 0);
        b_cyc(1, 32'h00209463);
        b_cyc(0, 32'h00209463);
        chk("B_FETCH", "illegal", b_ill, 0);
        chk("B_FETCH", "instret", b_cnt, 0);
        b_cyc(0, 32'h00209463);
        b_cyc(0, 32'h00209463);
        chk("B_HALT_BNE", "illegal", b_ill, 1);
        chk("B_HALT_BNE", "pcWrite", b_pcw, 0);

        // Main instance through the scoreboard.
        e = mk("RESET", -1, -1, -1, -1, -1, -1);
        cyc(e, 1, 1, 0, 0, 32'h0);
        run_instr(32'h002081B3, 0, 0, 0, 1, 0, 0);   // add
        run_instr(32'h0000A183, 2, 3, 0, 1, 0, 0);   // lw with waits
        run_instr(32'h00209463, 0, 0, 0, 1, 1, 0);   // bne, not taken
        run_instr(32'h00209463, 0, 0, 0, 1, 0, 0);   // bne, taken
        run_instr(32'h0000007F, 0, 0, 0, 20, 0, 0);  // illegal op, long halt
        run_instr(32'h0030A023, 1, 0, 1, 1, 0, 0);   // sw aborted by reset
        run_instr(32'h0020C1B3, 0, 0, 0, 1, 0, 0);   // xor
        run_instr(32'h0030A023, 0, 2, 0, 1, 0, 0);   // sw with waits
        run_instr(32'h008000EF, 0, 0, 0, 1, 0, 0);   // jal

        for (int n = 0; n < 220; n++) begin
            ins = $urandom;
            k   = $urandom_range(0, 9);
            case (k)
                0:       ins[6:0] = OPC_LOAD;
                1:       ins[6:0] = OPC_STORE;
                2, 3: begin
                    ins[6:0]   = OPC_R;
                    ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                end
                4, 5:    ins[6:0] = OPC_I;
                6:       ins[6:0] = OPC_BR;
                7:       ins[6:0] = OPC_JAL;
                8:       ins[6:0] = 7'($urandom);
                default: ins[6:0] = 7'h7F;
            endcase
            run_instr(ins, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
                      $urandom_range(1, 4), rb(), rb());
        end

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d records left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
